data_mem_lat: RTL and testbench

- Parametrised, latency-modelled data memory backing the data cache.
- Serves single-outstanding requests: line read (cache refill), word write with byte enables (write-through), and full-line write (write-back).
- Completion is signalled by a one-cycle ready pulse after a programmable number of cycles; read data is registered and held stable.
- Sits between the cache controller and nothing else; its contents are the architectural data space.

---
 rtl/data_mem_pkg.sv | 26 ++
 rtl/data_mem_if.sv | 30 +++
 rtl/data_mem_array.sv | 52 +++++
 rtl/data_mem_lat.sv | 103 ++++++++++
 tb/tb_data_mem_lat.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the latency-modelled data memory.
// Module-level widths are derived from each instance's own parameters.
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_WPL    = 4;
  localparam int DEF_LAT    = 3;
  localparam int DEF_LINE_W = DEF_DATA_W * DEF_WPL;
  localparam int DEF_OFFS_W = clog2(DEF_WPL);
  localparam int DEF_CNT_W  = clog2(DEF_LAT + 1);

endpackage

// File: rtl/data_mem_if.sv
// Request/response bundle between the cache controller and data memory.
// The cache drives the master side; the memory is the slave.
interface data_mem_if #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4
);
  logic                             req_valid;
  logic                             req_we;
  logic                             req_line;
  logic [ADDR_W-1:0]                addr;
  logic [DATA_W-1:0]                wd;
  logic [DATA_W/8-1:0]              be;
  logic [DATA_W*WORDS_PER_LINE-1:0] wline;
  logic                             busy;
  logic                             ready;
  logic [DATA_W*WORDS_PER_LINE-1:0] rd_line;

  modport master (
    output req_valid, req_we, req_line,
    output addr, wd, be, wline,
    input  busy, ready, rd_line
  );

  modport slave (
    input  req_valid, req_we, req_line,
    input  addr, wd, be, wline,
    output busy, ready, rd_line
  );
endinterface

// File: rtl/data_mem_array.sv
// Storage: synchronous line read, full-line write, byte-masked word write.
// The array itself is never cleared; only the read register resets.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             re,
  input  logic                             we_word,
  input  logic                             we_line,
  input  logic [ADDR_W-1:0]                addr,
  input  logic [DATA_W-1:0]                wd,
  input  logic [DATA_W/8-1:0]              be,
  input  logic [DATA_W*WORDS_PER_LINE-1:0] wline,
  output logic [DATA_W*WORDS_PER_LINE-1:0] rd_line
);
  localparam int OFFS_W = clog2(WORDS_PER_LINE);
  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [ADDR_W-OFFS_W-1:0] line_idx;

  assign line_idx = addr[ADDR_W-1:OFFS_W];

  always_ff @(posedge clk) begin
    if (we_line) begin
      for (int w = 0; w < WORDS_PER_LINE; w++)
        mem[{line_idx, OFFS_W'(w)}] <=
          wline[w*DATA_W +: DATA_W];
    end else if (we_word) begin
      for (int b = 0; b < NB; b++)
        if (be[b])
          mem[addr][b*8 +: 8] <= wd[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_line <= '0;
    end else if (re) begin
      for (int w = 0; w < WORDS_PER_LINE; w++)
        rd_line[w*DATA_W +: DATA_W] <=
          mem[{line_idx, OFFS_W'(w)}];
    end
  end

endmodule

// File: rtl/data_mem_lat.sv
// Latency-modelled data memory: single outstanding request,
// commit after LATENCY cycles, one-cycle ready pulse.
module data_mem_lat
  import data_mem_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LATENCY        = 3
) (
  input logic       clk,
  input logic       reset,
  data_mem_if.slave bus
);
  localparam int LINE_W = DATA_W * WORDS_PER_LINE;
  localparam int CNT_W  = clog2(LATENCY + 1);
  localparam int NB     = DATA_W / 8;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;
  logic               ready_q;
  logic               c_we;
  logic               c_line;
  logic [ADDR_W-1:0]  c_addr;
  logic [DATA_W-1:0]  c_wd;
  logic [NB-1:0]      c_be;
  logic [LINE_W-1:0]  c_wline;
  logic               accept;
  logic               commit;

  // The edge that ends DONE may accept, giving LATENCY+1 spacing.
  assign accept = bus.req_valid &&
                  (state == IDLE || state == DONE);
  assign commit = !reset && state == WAIT &&
                  cnt == CNT_W'(LATENCY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            state  <= WAIT;
            cnt    <= CNT_W'(1);
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
            cnt    <= '0;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(LATENCY)) begin
            state   <= DONE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      c_we    <= bus.req_we;
      c_line  <= bus.req_line;
      c_addr  <= bus.addr;
      c_wd    <= bus.wd;
      c_be    <= bus.be;
      c_wline <= bus.wline;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;

  data_mem_array #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .re      (commit && !c_we),
    .we_word (commit && c_we && !c_line),
    .we_line (commit && c_we && c_line),
    .addr    (c_addr),
    .wd      (c_wd),
    .be      (c_be),
    .wline   (c_wline),
    .rd_line (bus.rd_line)
  );

endmodule

// File: tb/tb_data_mem_lat.sv
// Scoreboard bench for data_mem_lat at LATENCY 3, 1 and 6.
// Issue pushes expected response; monitor pops on each ready.
module tb_data_mem_lat;
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_if #(.ADDR_W(10), .DATA_W(32), .WORDS_PER_LINE(4)) b3 ();
  data_mem_if #(.ADDR_W(10), .DATA_W(32), .WORDS_PER_LINE(4)) b1 ();
  data_mem_if #(.ADDR_W(10), .DATA_W(32), .WORDS_PER_LINE(4)) b6 ();

  data_mem_lat #(.ADDR_W(10), .DATA_W(32), .WORDS_PER_LINE(4), .LATENCY(3))
    u3 (.clk(clk), .reset(reset), .bus(b3));
  data_mem_lat #(.ADDR_W(10), .DATA_W(32), .WORDS_PER_LINE(4), .LATENCY(1))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  data_mem_lat #(.ADDR_W(10), .DATA_W(32), .WORDS_PER_LINE(4), .LATENCY(6))
    u6 (.clk(clk), .reset(reset), .bus(b6));

  typedef struct {
    logic [127:0] line;
    int           due;
  } exp_t;

  exp_t         q [3][$];
  logic [127:0] held [3];
  int           lat [3] = '{3, 1, 6};
  int           cyc = 0;
  int           vecs = 0;
  int           errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input int d, input bit v, input bit we,
                       input bit ln, input logic [9:0] a,
                       input logic [31:0] w, input logic [3:0] e,
                       input logic [127:0] wl);
    case (d)
      0: begin
        b3.req_valid = v; b3.req_we = we; b3.req_line = ln;
        b3.addr = a; b3.wd = w; b3.be = e; b3.wline = wl;
      end
      1: begin
        b1.req_valid = v; b1.req_we = we; b1.req_line = ln;
        b1.addr = a; b1.wd = w; b1.be = e; b1.wline = wl;
      end
      default: begin
        b6.req_valid = v; b6.req_we = we; b6.req_line = ln;
        b6.addr = a; b6.wd = w; b6.be = e; b6.wline = wl;
      end
    endcase
  endtask

  function automatic logic get_busy(input int d);
    case (d)
      0:       return b3.busy;
      1:       return b1.busy;
      default: return b6.busy;
    endcase
  endfunction

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (get_busy(d) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      vecs++; errs++;
      $display("FAIL busy_timeout d%0d got busy=1 want 0", d);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input int d, input bit we, input bit ln,
                       input logic [9:0] a, input logic [31:0] w,
                       input logic [3:0] e, input logic [127:0] wl,
                       input logic [127:0] exp_line);
    exp_t x;
    wait_idle(d);
    drive(d, 1'b1, we, ln, a, w, e, wl);
    if (!we) held[d] = exp_line;
    x.line = held[d];
    x.due  = cyc + 1 + lat[d];
    q[d].push_back(x);
    @(negedge clk);
    vecs++;
    if (!get_busy(d)) begin
      errs++;
      $display("FAIL busy_after_accept d%0d got 0 want 1", d);
    end
    drive(d, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic mon(input int d, input logic [127:0] rl);
    exp_t x;
    if (q[d].size() == 0) begin
      vecs++; errs++;
      $display("FAIL unexpected_ready d%0d cyc %0d got ready=1 want 0",
               d, cyc);
    end else begin
      x = q[d].pop_front();
      vecs++;
      if (cyc != x.due) begin
        errs++;
        $display("FAIL ready_time d%0d got cyc %0d want %0d",
                 d, cyc, x.due);
      end
      vecs++;
      if (rl !== x.line) begin
        errs++;
        $display("FAIL rd_line d%0d got %h want %h", d, rl, x.line);
      end
    end
  endtask

  always @(negedge clk) begin
    if (b3.ready) mon(0, b3.rd_line);
    if (b1.ready) mon(1, b1.rd_line);
    if (b6.ready) mon(2, b6.rd_line);
  end

  localparam logic [127:0] L1 =
    128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L1W =
    128'h44444444_33333333_22BB22DD_11111111;
  localparam logic [127:0] L2 =
    128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] L3 =
    128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA;
  localparam logic [127:0] L3W =
    128'h0F0F0F0F_F0F0F0F0_555555FF_AAAAAAAA;
  localparam logic [127:0] L4 =
    128'h13579BDF_2468ACE0_FEDCBA98_76543210;
  localparam logic [127:0] L4W =
    128'hA5579BDF_2468ACE0_FEDCBA98_76543210;
  localparam logic [127:0] T1 =
    128'h00000000_00000000_12345678_00000000;

  initial begin
    int n;
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      held[d] = '0;
      drive(d, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if ({b3.busy, b3.ready, b3.rd_line} != '0) begin
        errs++;
        $display("FAIL reset_idle got busy=%b ready=%b rd=%h want 0",
                 b3.busy, b3.ready, b3.rd_line);
      end
    end

    // Line write, aligned read back, byte-masked word write, be=0 no-op.
    issue(0, 1, 1, 10'h013, '0, '0, L1, '0);
    issue(0, 0, 0, 10'h010, '0, '0, '0, L1);
    issue(0, 1, 0, 10'h011, 32'hAABBCCDD, 4'b0101, '0, '0);
    issue(0, 0, 0, 10'h012, '0, '0, '0, L1W);
    issue(0, 1, 0, 10'h010, 32'hFFFFFFFF, 4'b0000, '0, '0);
    issue(0, 0, 0, 10'h010, '0, '0, '0, L1W);

    // Inputs churn while busy; extra req_valid during WAIT is ignored.
    issue(0, 1, 1, 10'h014, '0, '0, '0, '0);
    issue(0, 1, 0, 10'h015, 32'h12345678, 4'hF, '0, '0);
    for (int i = 0; i < 3; i++) begin
      drive(0, i < 2, (i % 2) == 1, 1'b1, 10'h3FF - 10'(i),
            32'hFFFF0000 ^ 32'(i), 4'hF, '1);
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    issue(0, 0, 0, 10'h014, '0, '0, '0, T1);

    // Reset one cycle into a word write: nothing commits.
    issue(0, 1, 1, 10'h020, '0, '0, L2, '0);
    issue(0, 0, 0, 10'h020, '0, '0, '0, L2);
    wait_idle(0);
    drive(0, 1'b1, 1'b1, 1'b0, 10'h020, 32'h0, 4'hF, '0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) held[d] = '0;
    vecs++;
    if (b3.busy || b3.ready) begin
      errs++;
      $display("FAIL reset_mid_busy got busy=%b ready=%b want 0 0",
               b3.busy, b3.ready);
    end
    vecs++;
    if (b3.rd_line !== '0) begin
      errs++;
      $display("FAIL reset_rd_line got %h want 0", b3.rd_line);
    end
    repeat (4) @(negedge clk);
    issue(0, 0, 0, 10'h020, '0, '0, '0, L2);

    // LATENCY=1: back-to-back spacing of 2.
    issue(1, 1, 1, 10'h100, '0, '0, L3, '0);
    issue(1, 0, 0, 10'h100, '0, '0, '0, L3);
    issue(1, 1, 1, 10'h104, '0, '0, L4, '0);
    issue(1, 0, 0, 10'h107, '0, '0, '0, L4);
    issue(1, 1, 0, 10'h101, 32'h000000FF, 4'b0001, '0, '0);
    issue(1, 0, 0, 10'h100, '0, '0, '0, L3W);

    // LATENCY=6 at the top of the address space.
    issue(2, 1, 1, 10'h3F8, '0, '0, L4, '0);
    issue(2, 0, 0, 10'h3F8, '0, '0, '0, L4);
    issue(2, 1, 0, 10'h3FB, 32'hA5A5A5A5, 4'b1000, '0, '0);
    issue(2, 0, 0, 10'h3F9, '0, '0, '0, L4W);

    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (n >= 50) begin
      errs++;
      $display("FAIL drain got %0d pending want 0",
               q[0].size() + q[1].size() + q[2].size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
